ext_lights_multi: RTL and testbench

Parametrised multi-channel exterior-lighting controller, successor to the single-channel `ext_lights` block in the smart-home automation top level. Each channel compares its own 8-bit (parametrisable) luminosity sensor against separate on/off thresholds (hysteresis). It debounces the comparison over a configurable number of cycles and enforces a minimum on-time. It also supports per-channel enable and manual force-on, and reports a registered light vector plus a count of lit channels.

---
 rtl/home_pkg.sv | 18 +
 rtl/ext_light_ch.sv | 110 +++++++++++
 rtl/ext_lights_multi.sv | 54 +++++
 tb/tb_ext_lights_multi.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/home_pkg.sv
// Shared types and default constants for the smart-home automation blocks.
// Holds the exterior-light channel state encoding and its default thresholds.
package home_pkg;

   typedef enum logic [1:0] {
      ST_OFF      = 2'd0,
      ST_PEND_ON  = 2'd1,
      ST_ON       = 2'd2,
      ST_PEND_OFF = 2'd3
   } light_state_t;

   localparam int DEF_LUM_W      = 8;
   localparam int DEF_ON_THRESH  = 30;
   localparam int DEF_OFF_THRESH = 60;
   localparam int DEF_DEBOUNCE   = 4;
   localparam int DEF_HOLD       = 16;

endpackage

// File: rtl/ext_light_ch.sv
// One exterior-light channel: hysteresis thresholds, debounce, minimum on-time,
// enable/force overrides and a registered lamp output.
module ext_light_ch
   import home_pkg::*;
#(
   parameter int LUM_W      = DEF_LUM_W,
   parameter int ON_THRESH  = DEF_ON_THRESH,
   parameter int OFF_THRESH = DEF_OFF_THRESH,
   parameter int DEBOUNCE   = DEF_DEBOUNCE,
   parameter int HOLD       = DEF_HOLD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LUM_W-1:0] lum,
   input  logic             en,
   input  logic             force_on,
   output logic             light,
   output light_state_t     state
);

   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam int HW = $clog2(HOLD + 1);

   localparam logic [LUM_W-1:0] ON_T      = LUM_W'(ON_THRESH);
   localparam logic [LUM_W-1:0] OFF_T     = LUM_W'(OFF_THRESH);
   localparam logic [DW-1:0]    DCNT_LAST = DW'(DEBOUNCE - 1);
   localparam logic [HW-1:0]    HCNT_MAX  = HW'(HOLD);

   light_state_t    state_n;
   logic [DW-1:0]   dcnt, dcnt_n;
   logic [HW-1:0]   hcnt, hcnt_n;
   logic            light_n;
   logic            dark, bright;

   // Equality with either threshold is deliberately neither dark nor bright.
   assign dark   = (lum < ON_T);
   assign bright = (lum > OFF_T);

   always_comb begin
      state_n = state;
      dcnt_n  = dcnt;
      hcnt_n  = hcnt;
      if (!en) begin
         state_n = ST_OFF;
         dcnt_n  = '0;
         hcnt_n  = '0;
      end else begin
         case (state)
            ST_OFF: begin
               if (dark) begin
                  state_n = ST_PEND_ON;
                  dcnt_n  = DW'(1);
               end
            end
            ST_PEND_ON: begin
               if (!dark) begin
                  state_n = ST_OFF;
                  dcnt_n  = '0;
               end else if (dcnt == DCNT_LAST) begin
                  state_n = ST_ON;
                  dcnt_n  = '0;
                  hcnt_n  = '0;
               end else begin
                  dcnt_n = dcnt + DW'(1);
               end
            end
            ST_ON: begin
               if (hcnt != HCNT_MAX) hcnt_n = hcnt + HW'(1);
               // Bright only counts once the minimum on-time has elapsed.
               if (bright && hcnt == HCNT_MAX) begin
                  state_n = ST_PEND_OFF;
                  dcnt_n  = DW'(1);
               end
            end
            ST_PEND_OFF: begin
               if (!bright) begin
                  state_n = ST_ON;
                  dcnt_n  = '0;
               end else if (dcnt == DCNT_LAST) begin
                  state_n = ST_OFF;
                  dcnt_n  = '0;
               end else begin
                  dcnt_n = dcnt + DW'(1);
               end
            end
            default: begin
               state_n = ST_OFF;
               dcnt_n  = '0;
               hcnt_n  = '0;
            end
         endcase
      end
      light_n = en & (force_on | (state_n == ST_ON) | (state_n == ST_PEND_OFF));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_OFF;
         dcnt  <= '0;
         hcnt  <= '0;
         light <= 1'b0;
      end else begin
         state <= state_n;
         dcnt  <= dcnt_n;
         hcnt  <= hcnt_n;
         light <= light_n;
      end
   end

endmodule

// File: rtl/ext_lights_multi.sv
// Multi-channel exterior-lighting controller: N_CH independent channels plus a
// popcount of lit lamps. Ch_state exposes each channel's FSM state (2 bits each).
module ext_lights_multi
   import home_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int LUM_W      = DEF_LUM_W,
   parameter int ON_THRESH  = DEF_ON_THRESH,
   parameter int OFF_THRESH = DEF_OFF_THRESH,
   parameter int DEBOUNCE   = DEF_DEBOUNCE,
   parameter int HOLD       = DEF_HOLD
) (
   input  logic                        CLK,
   input  logic                        Reset,
   input  logic [N_CH*LUM_W-1:0]       Lum_sen,
   input  logic [N_CH-1:0]             Ch_en,
   input  logic [N_CH-1:0]             Force_on,
   output logic [N_CH-1:0]             Ext_light,
   output logic [$clog2(N_CH+1)-1:0]   Lit_cnt,
   output logic [2*N_CH-1:0]           Ch_state
);

   localparam int CW = $clog2(N_CH + 1);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      light_state_t ch_state;

      ext_light_ch #(
         .LUM_W      (LUM_W),
         .ON_THRESH  (ON_THRESH),
         .OFF_THRESH (OFF_THRESH),
         .DEBOUNCE   (DEBOUNCE),
         .HOLD       (HOLD)
      ) u_ch (
         .clk      (CLK),
         .rst      (Reset),
         .lum      (Lum_sen[g*LUM_W +: LUM_W]),
         .en       (Ch_en[g]),
         .force_on (Force_on[g]),
         .light    (Ext_light[g]),
         .state    (ch_state)
      );

      assign Ch_state[2*g +: 2] = ch_state;
   end

   always_comb begin
      Lit_cnt = '0;
      for (int i = 0; i < N_CH; i++) begin
         Lit_cnt = Lit_cnt + CW'(Ext_light[i]);
      end
   end

endmodule

// File: tb/tb_ext_lights_multi.sv
// Bench for ext_lights_multi: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed lamp timings.
module tb_ext_lights_multi;

   localparam int N_CH = 4;
   localparam int LW   = 8;
   localparam int DEB  = 4;
   localparam int HLD  = 16;
   localparam int ONT  = 30;
   localparam int OFFT = 60;

   logic                  CLK;
   logic                  Reset;
   logic [N_CH*LW-1:0]    Lum_sen;
   logic [N_CH-1:0]       Ch_en;
   logic [N_CH-1:0]       Force_on;
   logic [N_CH-1:0]       Ext_light;
   logic [2:0]            Lit_cnt;
   logic [2*N_CH-1:0]     Ch_state;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 0;

   ext_lights_multi #(.N_CH(N_CH)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Lum_sen   (Lum_sen),
      .Ch_en     (Ch_en),
      .Force_on  (Force_on),
      .Ext_light (Ext_light),
      .Lit_cnt   (Lit_cnt),
      .Ch_state  (Ch_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: a channel is "lit" once it sees DEB consecutive dark
   // samples; once lit for HLD cycles, DEB consecutive bright samples unlight it.
   bit            m_lit [N_CH];
   int            m_run [N_CH];
   int            m_age [N_CH];
   logic [N_CH-1:0] exp_light;

   always @(posedge CLK or posedge Reset) begin
      bit l;
      int r, a, v;
      for (int i = 0; i < N_CH; i++) begin
         if (Reset || !Ch_en[i]) begin
            l = 0; r = 0; a = 0;
         end else begin
            l = m_lit[i]; r = m_run[i]; a = m_age[i];
            v = int'(Lum_sen[i*LW +: LW]);
            if (!l) begin
               r = (v < ONT) ? r + 1 : 0;
               if (r == DEB) begin
                  l = 1; r = 0; a = 0;
               end
            end else begin
               r = (v > OFFT && a == HLD) ? r + 1 : 0;
               a = (a < HLD) ? a + 1 : HLD;
               if (r == DEB) begin
                  l = 0; r = 0; a = 0;
               end
            end
         end
         m_lit[i] <= l;
         m_run[i] <= r;
         m_age[i] <= a;
         exp_light[i] <= Reset ? 1'b0 : (Ch_en[i] & (Force_on[i] | l));
      end
   end

   // scoreboard: every-cycle comparison against the model
   always @(negedge CLK) begin
      if (check_en) begin
         n_tests++;
         if (Ext_light !== exp_light) begin
            n_fail++;
            $display("FAIL model_ext_light t=%0t got=%b exp=%b", $time, Ext_light, exp_light);
         end
         n_tests++;
         if (Lit_cnt !== 3'($countones(exp_light))) begin
            n_fail++;
            $display("FAIL model_lit_cnt t=%0t got=%0d exp=%0d", $time, Lit_cnt, $countones(exp_light));
         end
      end
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic set_lum(input int ch, input logic [7:0] v);
      Lum_sen[ch*LW +: LW] = v;
   endtask

   task automatic set_all(input logic [7:0] v);
      for (int i = 0; i < N_CH; i++) Lum_sen[i*LW +: LW] = v;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0d exp=%0d", name, $time, got, exp);
      end
   endtask

   initial begin
      Reset    = 1'b1;
      Ch_en    = '1;
      Force_on = '0;
      set_all(8'd90);
      step(2);
      check("reset_light", int'(Ext_light), 0);
      check("reset_cnt", int'(Lit_cnt), 0);
      Reset = 1'b0;
      check_en = 1;
      step(5);

      // basic turn-on on ch0
      set_lum(0, 8'd20);
      step(3);
      check("t1_not_yet", int'(Ext_light[0]), 0);
      step(1);
      check("t1_rise", int'(Ext_light[0]), 1);
      check("t1_ch1_off", int'(Ext_light[1]), 0);
      check("t1_cnt", int'(Lit_cnt), 1);

      // immediately bright: falls HOLD+DEBOUNCE edges after ON entry
      set_lum(0, 8'd90);
      step(19);
      check("t3b_still_on", int'(Ext_light[0]), 1);
      step(1);
      check("t3b_fall", int'(Ext_light[0]), 0);

      // glitch rejection
      set_lum(0, 8'd20);
      step(3);
      set_lum(0, 8'd90);
      step(5);
      check("t2_glitch", int'(Ext_light[0]), 0);
      set_lum(0, 8'd20);
      step(3);
      check("t2_not_yet", int'(Ext_light[0]), 0);
      step(1);
      check("t2_rise", int'(Ext_light[0]), 1);

      // hysteresis band keeps lamp on, then bright turns it off after debounce
      set_lum(0, 8'd45);
      step(100);
      check("t3_band_on", int'(Ext_light[0]), 1);
      set_lum(0, 8'd90);
      step(3);
      check("t3_pend_off", int'(Ext_light[0]), 1);
      step(1);
      check("t3_fall", int'(Ext_light[0]), 0);

      // threshold equality
      set_lum(0, 8'd30);
      step(10);
      check("t6_eq_on", int'(Ext_light[0]), 0);
      set_lum(0, 8'd29);
      step(3);
      check("t6_29_wait", int'(Ext_light[0]), 0);
      step(1);
      check("t6_29_rise", int'(Ext_light[0]), 1);
      set_lum(0, 8'd60);
      step(30);
      check("t6_eq_off", int'(Ext_light[0]), 1);
      set_lum(0, 8'd61);
      step(3);
      check("t6_61_wait", int'(Ext_light[0]), 1);
      step(1);
      check("t6_61_fall", int'(Ext_light[0]), 0);

      // override priority on ch2
      Force_on[2] = 1'b1;
      step(1);
      check("t4_force", int'(Ext_light[2]), 1);
      Ch_en[2] = 1'b0;
      step(1);
      check("t4_disable", int'(Ext_light[2]), 0);
      Ch_en[2] = 1'b1;
      step(1);
      check("t4_reenable", int'(Ext_light[2]), 1);
      Force_on[2] = 1'b0;
      step(1);
      check("t4_release", int'(Ext_light[2]), 0);

      // all channels lit, then asynchronous reset mid-cycle
      set_all(8'd20);
      step(3);
      check("t5_cnt_wait", int'(Lit_cnt), 0);
      step(1);
      check("t5_cnt4", int'(Lit_cnt), 4);
      #2 Reset = 1'b1;
      #1;
      check("t5_rst_light", int'(Ext_light), 0);
      check("t5_rst_cnt", int'(Lit_cnt), 0);
      #1 Reset = 1'b0;
      step(3);
      check("t5_relight_wait", int'(Lit_cnt), 0);
      step(1);
      check("t5_relight", int'(Ext_light), 15);

      // releasing force leaves an FSM-lit lamp on
      Force_on[1] = 1'b1;
      step(1);
      check("force_on_lit", int'(Ext_light), 15);
      Force_on[1] = 1'b0;
      step(1);
      check("force_rel_lit", int'(Ext_light), 15);

      // mixed per-channel runs, checked by the model each cycle
      for (int k = 0; k < 120; k++) begin
         for (int i = 0; i < N_CH; i++) begin
            case ($urandom_range(0, 6))
               0: set_lum(i, 8'd20);
               1: set_lum(i, 8'd29);
               2: set_lum(i, 8'd30);
               3: set_lum(i, 8'd45);
               4: set_lum(i, 8'd60);
               5: set_lum(i, 8'd61);
               default: set_lum(i, 8'd200);
            endcase
            Force_on[i] = ($urandom_range(0, 9) == 0);
            Ch_en[i]    = ($urandom_range(0, 14) != 0);
         end
         step($urandom_range(1, 24));
      end

      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
